// File: rtl/user_wr_pkt_buffer.sv
// Store-and-forward write packet buffer: holds each packet until tlast, then emits a length descriptor and the beats.
// Optional USER_WR_PKT_STATS_EN adds saturating packet/byte/truncation counters.
module user_wr_pkt_buffer #(
    parameter int AXI_DATA_BITS = 512,
    parameter int PID_BITS      = 6,
    parameter int DATA_DEPTH    = 64,
    parameter int DESC_DEPTH    = 4,
    parameter int MAX_PKT_BEATS = 64,
    localparam int BEAT_W       = $clog2(MAX_PKT_BEATS) + 1,
    localparam int KEEP_W       = AXI_DATA_BITS / 8
) (
    input  logic                     aclk_i,
    input  logic                     areset_i,
    input  logic [AXI_DATA_BITS-1:0] s_axis_tdata_i,
    input  logic [KEEP_W-1:0]        s_axis_tkeep_i,
    input  logic [PID_BITS-1:0]      s_axis_tid_i,
    input  logic                     s_axis_tlast_i,
    input  logic                     s_axis_tvalid_i,
    output logic                     s_axis_tready_o,
    output logic [AXI_DATA_BITS-1:0] m_axis_tdata_o,
    output logic [KEEP_W-1:0]        m_axis_tkeep_o,
    output logic [PID_BITS-1:0]      m_axis_tid_o,
    output logic                     m_axis_tlast_o,
    output logic                     m_axis_tvalid_o,
    input  logic                     m_axis_tready_i,
    output logic                     m_desc_valid_o,
    input  logic                     m_desc_ready_i,
    output logic [PID_BITS-1:0]      m_desc_tid_o,
    output logic [31:0]              m_desc_len_o,
    output logic [BEAT_W-1:0]        m_desc_beats_o,
    output logic                     m_desc_err_o,
    output logic                     busy_o
`ifdef USER_WR_PKT_STATS_EN
   ,output logic [31:0]              stat_pkts_o,
    output logic [47:0]              stat_bytes_o,
    output logic [15:0]              stat_trunc_o
`endif
);
    localparam int DA_W   = $clog2(DATA_DEPTH);
    localparam int DS_W   = $clog2(DESC_DEPTH);
    localparam int DW_W   = AXI_DATA_BITS + KEEP_W + 1;
    localparam int DESC_W = PID_BITS + 32 + BEAT_W + 1;

    if (MAX_PKT_BEATS > DATA_DEPTH) begin : g_bad_max
        $error("MAX_PKT_BEATS must not exceed DATA_DEPTH");
    end

    typedef enum logic [1:0] {IN_IDLE, IN_PKT, IN_DROP} in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_DESC, OUT_DATA} out_state_t;

    in_state_t             in_state_q, in_state_d;
    out_state_t            out_state_q, out_state_d;
    logic [PID_BITS-1:0]   tid_q, tid_d, dtid_q, dtid_d;
    logic [31:0]           byte_q, byte_d, dlen_q, dlen_d;
    logic [BEAT_W-1:0]     beats_q, beats_d, dbeats_q, dbeats_d, rem_q, rem_d;
    logic                  derr_q, derr_d;

    logic [DW_W-1:0]       d_mem [DATA_DEPTH];
    logic [DESC_W-1:0]     ds_mem [DESC_DEPTH];
    logic [DA_W:0]         d_wr_q, d_rd_q, d_cnt;
    logic [DS_W:0]         ds_wr_q, ds_rd_q, ds_cnt;
    logic                  d_full, d_empty, ds_full, ds_empty;
    logic                  d_push, d_pop, ds_push, ds_pop, push_last;
    logic                  s_ready, s_acc, first;
    logic [BEAT_W-1:0]     beat_n;
    logic [31:0]           byte_n;
    logic [PID_BITS-1:0]   pkt_tid;
    logic [DW_W-1:0]       d_head;
    logic [DESC_W-1:0]     ds_head;
    logic                  rd_last, m_valid, desc_valid;

    assign d_cnt    = d_wr_q - d_rd_q;
    assign ds_cnt   = ds_wr_q - ds_rd_q;
    assign d_full   = d_cnt == (DA_W+1)'(DATA_DEPTH);
    assign ds_full  = ds_cnt == (DS_W+1)'(DESC_DEPTH);
    assign d_empty  = d_wr_q == d_rd_q;
    assign ds_empty = ds_wr_q == ds_rd_q;
    assign d_head   = d_mem[d_rd_q[DA_W-1:0]];
    assign ds_head  = ds_mem[ds_rd_q[DS_W-1:0]];
    assign rd_last  = d_head[DW_W-1];

    always_comb begin
        in_state_d = in_state_q;
        tid_d      = tid_q;
        byte_d     = byte_q;
        beats_d    = beats_q;
        d_push     = 1'b0;
        ds_push    = 1'b0;
        push_last  = s_axis_tlast_i;
        s_ready    = (in_state_q == IN_DROP) || (!d_full && !ds_full);
        s_acc      = s_axis_tvalid_i && s_ready;
        first      = in_state_q == IN_IDLE;
        beat_n     = first ? BEAT_W'(1) : beats_q + BEAT_W'(1);
        byte_n     = (first ? 32'd0 : byte_q) + 32'($countones(s_axis_tkeep_i));
        pkt_tid    = first ? s_axis_tid_i : tid_q;
        if (s_acc) begin
            if (in_state_q == IN_DROP) begin
                if (s_axis_tlast_i) in_state_d = IN_IDLE;
            end else begin
                d_push  = 1'b1;
                tid_d   = pkt_tid;
                byte_d  = byte_n;
                beats_d = beat_n;
                if (s_axis_tlast_i) begin
                    ds_push    = 1'b1;
                    in_state_d = IN_IDLE;
                end else if (beat_n == BEAT_W'(MAX_PKT_BEATS)) begin
                    // Oversized packet: close it here and swallow the rest up to tlast.
                    ds_push    = 1'b1;
                    push_last  = 1'b1;
                    in_state_d = IN_DROP;
                end else begin
                    in_state_d = IN_PKT;
                end
            end
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        dtid_d      = dtid_q;
        dlen_d      = dlen_q;
        dbeats_d    = dbeats_q;
        derr_d      = derr_q;
        rem_d       = rem_q;
        desc_valid  = 1'b0;
        m_valid     = 1'b0;
        ds_pop      = 1'b0;
        d_pop       = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if (!ds_empty) begin
                    {dtid_d, dlen_d, dbeats_d, derr_d} = ds_head;
                    out_state_d = OUT_DESC;
                end
            end
            OUT_DESC: begin
                desc_valid = 1'b1;
                if (m_desc_ready_i) begin
                    ds_pop      = 1'b1;
                    rem_d       = dbeats_q;
                    out_state_d = OUT_DATA;
                end
            end
            OUT_DATA: begin
                m_valid = !d_empty;
                if (m_valid && m_axis_tready_i) begin
                    d_pop = 1'b1;
                    rem_d = rem_q - BEAT_W'(1);
                    if (rd_last) out_state_d = OUT_IDLE;
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            in_state_q  <= IN_IDLE;
            out_state_q <= OUT_IDLE;
            tid_q       <= '0;
            byte_q      <= '0;
            beats_q     <= '0;
            dtid_q      <= '0;
            dlen_q      <= '0;
            dbeats_q    <= '0;
            derr_q      <= 1'b0;
            rem_q       <= '0;
            d_wr_q      <= '0;
            d_rd_q      <= '0;
            ds_wr_q     <= '0;
            ds_rd_q     <= '0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            tid_q       <= tid_d;
            byte_q      <= byte_d;
            beats_q     <= beats_d;
            dtid_q      <= dtid_d;
            dlen_q      <= dlen_d;
            dbeats_q    <= dbeats_d;
            derr_q      <= derr_d;
            rem_q       <= rem_d;
            if (d_push)  d_wr_q  <= d_wr_q + 1'b1;
            if (d_pop)   d_rd_q  <= d_rd_q + 1'b1;
            if (ds_push) ds_wr_q <= ds_wr_q + 1'b1;
            if (ds_pop)  ds_rd_q <= ds_rd_q + 1'b1;
        end
    end

    always_ff @(posedge aclk_i) begin
        if (d_push)  d_mem[d_wr_q[DA_W-1:0]]   <= {push_last, s_axis_tkeep_i, s_axis_tdata_i};
        if (ds_push) ds_mem[ds_wr_q[DS_W-1:0]] <= {pkt_tid, byte_n, beat_n, !s_axis_tlast_i};
    end

    assign s_axis_tready_o = s_ready;
    assign m_axis_tvalid_o = m_valid;
    assign m_axis_tdata_o  = m_valid ? d_head[AXI_DATA_BITS-1:0] : '0;
    assign m_axis_tkeep_o  = m_valid ? d_head[DW_W-2 -: KEEP_W] : '0;
    assign m_axis_tlast_o  = m_valid && rd_last;
    assign m_axis_tid_o    = m_valid ? dtid_q : '0;
    assign m_desc_valid_o  = desc_valid;
    assign m_desc_tid_o    = dtid_q;
    assign m_desc_len_o    = dlen_q;
    assign m_desc_beats_o  = dbeats_q;
    assign m_desc_err_o    = derr_q;
    assign busy_o          = !d_empty || !ds_empty || (in_state_q != IN_IDLE);

`ifndef SYNTHESIS
    // The stored tlast drives the FSM; the beat counter is only a consistency cross-check.
    rem_tlast_agree: assert property (@(posedge aclk_i) disable iff (areset_i)
        d_pop |-> ((rem_q == BEAT_W'(1)) == rd_last));
`endif

`ifdef USER_WR_PKT_STATS_EN
    logic [31:0] pkts_q;
    logic [47:0] bytes_q;
    logic [15:0] trunc_q;
    logic [48:0] bytes_sum;

    assign bytes_sum = {1'b0, bytes_q} + 49'(dlen_q);

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            pkts_q  <= '0;
            bytes_q <= '0;
            trunc_q <= '0;
        end else if (ds_pop) begin
            if (pkts_q != '1) pkts_q <= pkts_q + 1'b1;
            bytes_q <= bytes_sum[48] ? '1 : bytes_sum[47:0];
            if (derr_q && trunc_q != '1) trunc_q <= trunc_q + 1'b1;
        end
    end

    assign stat_pkts_o  = pkts_q;
    assign stat_bytes_o = bytes_q;
    assign stat_trunc_o = trunc_q;
`endif
endmodule
